// File: rtl/pipe_stage_reg.sv
// Ready/valid pipeline stage with a two-entry skid buffer, synchronous flush and bubble insertion.
// Optional saturating stall/flush statistics are built only when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic              main_v_q,    main_v_d;
  logic              skid_v_q,    skid_v_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_xfer_s;
  logic              out_xfer_s;

  // ready_o depends only on skid occupancy, so ready_i never reaches it combinationally.
  assign in_xfer_s  = valid_i & ~skid_v_q;
  assign out_xfer_s = main_v_q & ready_i;

  // Next-state for the head/skid pair; stored ctrl is kept zero whenever its slot is empty.
  always_comb begin
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      main_v_d    = 1'b0;
      skid_v_d    = 1'b0;
      main_ctrl_d = {CTRL_W{1'b0}};
      skid_ctrl_d = {CTRL_W{1'b0}};
    end else begin
      case ({main_v_q, skid_v_q})
        2'b00: begin
          if (in_xfer_s) begin
            main_v_d    = 1'b1;
            main_ctrl_d = ctrl_i;
            main_data_d = data_i;
          end else begin
            main_v_d    = 1'b0;
          end
        end
        2'b10: begin
          if (in_xfer_s && out_xfer_s) begin
            main_ctrl_d = ctrl_i;
            main_data_d = data_i;
          end else if (in_xfer_s) begin
            skid_v_d    = 1'b1;
            skid_ctrl_d = ctrl_i;
            skid_data_d = data_i;
          end else if (out_xfer_s) begin
            main_v_d    = 1'b0;
            main_ctrl_d = {CTRL_W{1'b0}};
          end else begin
            main_v_d    = 1'b1;
          end
        end
        2'b11: begin
          if (out_xfer_s) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_v_d    = 1'b0;
            skid_ctrl_d = {CTRL_W{1'b0}};
          end else begin
            skid_v_d    = 1'b1;
          end
        end
        default: begin
          // Skid-only occupancy is unreachable; collapse to EMPTY.
          main_v_d    = 1'b0;
          skid_v_d    = 1'b0;
          main_ctrl_d = {CTRL_W{1'b0}};
          skid_ctrl_d = {CTRL_W{1'b0}};
        end
      endcase
    end
  end

  // Storage registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_ctrl_q <= {CTRL_W{1'b0}};
      main_data_q <= {DATA_W{1'b0}};
      skid_ctrl_q <= {CTRL_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign ready_o = ~skid_v_q;
  assign valid_o = main_v_q;
  assign ctrl_o  = main_ctrl_q;
  assign data_o  = main_data_q;

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             discard_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // A head delivered during the flush cycle is not a discard.
  assign discard_s = (main_v_q & ~ready_i) | skid_v_q | (valid_i & ~skid_v_q);

  // Saturating counter next-state.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (main_v_q && !ready_i) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_i && discard_s) begin
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = {CNT_W{1'b0}};
  assign flush_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: streaming, backpressure, flush, bubble, reset, saturation, random.
module tb_pipe_stage_reg;
  localparam int CW = 8;
  localparam int DW = 96;
  localparam int NW = 4;

  typedef logic [CW+DW-1:0] ent_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [CW-1:0] ctrl_i = '0;
  logic [DW-1:0] data_i = '0;
  logic          flush_i = 1'b0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [CW-1:0] ctrl_o;
  logic [DW-1:0] data_o;
  logic [NW-1:0] stall_cnt_o;
  logic [NW-1:0] flush_cnt_o;

  int   checks = 0;
  int   failures = 0;
  ent_t exp_q[$];

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .ctrl_i(ctrl_i), .data_i(data_i), .flush_i(flush_i), .valid_o(valid_o),
    .ready_i(ready_i), .ctrl_o(ctrl_o), .data_o(data_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive one cycle (inputs at negedge), score any output transfer, return at the next negedge.
  task automatic xfer_cycle(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                            input logic r, input logic f);
    ent_t e;
    valid_i = v; ctrl_i = c; data_i = d; ready_i = r; flush_i = f;
    checks++;
    if (valid_o !== (exp_q.size() > 0)) begin
      failures++; $display("FAIL sb_valid: got %b want %b", valid_o, exp_q.size() > 0);
    end
    checks++;
    if (ready_o !== (exp_q.size() < 2)) begin
      failures++; $display("FAIL sb_ready: got %b want %b", ready_o, exp_q.size() < 2);
    end
    if (valid_o !== 1'b1) begin
      checks++;
      if (ctrl_o !== {CW{1'b0}}) begin
        failures++; $display("FAIL sb_bubble_ctrl: got %h want 00", ctrl_o);
      end
    end
    if (valid_o === 1'b1 && r && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({ctrl_o, data_o} !== e) begin
        failures++; $display("FAIL sb_entry: got %h/%h want %h/%h", ctrl_o, data_o, e[CW+DW-1:DW], e[DW-1:0]);
      end
    end
    if (f) exp_q.delete();
    else if (v && ready_o === 1'b1) exp_q.push_back({c, d});
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    valid_i = 1'b1; ctrl_i = 8'hA5; data_i = 96'h5; ready_i = 1'b0;
    @(negedge clk_i);
    do_reset();
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    checks++; if (ctrl_o !== 8'h00) begin failures++; $display("FAIL rst_ctrl: got %h want 00", ctrl_o); end
    checks++; if (data_o !== 96'h0) begin failures++; $display("FAIL rst_data: got %h want 0", data_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b want 1", ready_o); end
    checks++; if (stall_cnt_o !== 4'd0) begin failures++; $display("FAIL rst_stall: got %0d want 0", stall_cnt_o); end
    checks++; if (flush_cnt_o !== 4'd0) begin failures++; $display("FAIL rst_flush: got %0d want 0", flush_cnt_o); end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] dv [3];
    logic [CW-1:0] cv [3];
    dv[0] = 96'hAAAA_0000_0000_0000_0000_0001; cv[0] = 8'h11;
    dv[1] = 96'hBBBB_0000_0000_0000_0000_0002; cv[1] = 8'h22;
    dv[2] = 96'h0000_0000_0000_0000_0000_DEAD; cv[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      xfer_cycle(1'b1, cv[i], dv[i], 1'b1, 1'b0);
      checks++;
      if (valid_o !== 1'b1 || data_o !== dv[i] || ready_o !== 1'b1) begin
        failures++; $display("FAIL stream_%0d: got v=%b r=%b d=%h want v=1 r=1 d=%h", i, valid_o, ready_o, data_o, dv[i]);
      end
    end
    xfer_cycle(1'b0, 8'h00, 96'h0, 1'b1, 1'b0);
    checks++;
    if (valid_o !== 1'b0 || ctrl_o !== 8'h00 || data_o !== dv[2]) begin
      failures++; $display("FAIL bubble: got v=%b c=%h d=%h want v=0 c=00 d=%h", valid_o, ctrl_o, data_o, dv[2]);
    end
  endtask

  task automatic test_backpressure();
    logic [NW-1:0] s0;
    xfer_cycle(1'b1, 8'h41, 96'hA1, 1'b0, 1'b0);
    s0 = stall_cnt_o;
    xfer_cycle(1'b1, 8'h42, 96'hB2, 1'b0, 1'b0);
    checks++;
    if (ready_o !== 1'b0 || data_o !== 96'hA1) begin
      failures++; $display("FAIL bp_skid: got r=%b d=%h want r=0 d=a1", ready_o, data_o);
    end
    xfer_cycle(1'b0, 8'h00, 96'h0, 1'b1, 1'b0);
    checks++;
    if (ready_o !== 1'b1 || data_o !== 96'hB2 || valid_o !== 1'b1) begin
      failures++; $display("FAIL bp_drain: got r=%b v=%b d=%h want r=1 v=1 d=b2", ready_o, valid_o, data_o);
    end
    xfer_cycle(1'b0, 8'h00, 96'h0, 1'b1, 1'b0);
    checks++;
`ifdef PIPE_STAGE_STATS_EN
    if (stall_cnt_o !== s0 + 4'd1) begin failures++; $display("FAIL bp_stall_cnt: got %0d want %0d", stall_cnt_o, s0 + 4'd1); end
`else
    if (stall_cnt_o !== 4'd0) begin failures++; $display("FAIL bp_stall_cnt: got %0d want 0", stall_cnt_o); end
`endif
  endtask

  task automatic test_flush();
    logic [NW-1:0] f0;
    xfer_cycle(1'b1, 8'h51, 96'hA5, 1'b0, 1'b0);
    xfer_cycle(1'b1, 8'h52, 96'hB5, 1'b0, 1'b0);
    f0 = flush_cnt_o;
    xfer_cycle(1'b1, 8'h53, 96'hC5, 1'b0, 1'b1);
    checks++;
    if (valid_o !== 1'b0 || ctrl_o !== 8'h00 || ready_o !== 1'b1 || data_o !== 96'hA5) begin
      failures++; $display("FAIL flush_state: got v=%b c=%h r=%b d=%h want v=0 c=00 r=1 d=a5", valid_o, ctrl_o, ready_o, data_o);
    end
    checks++;
`ifdef PIPE_STAGE_STATS_EN
    if (flush_cnt_o !== f0 + 4'd1) begin failures++; $display("FAIL flush_cnt: got %0d want %0d", flush_cnt_o, f0 + 4'd1); end
`else
    if (flush_cnt_o !== 4'd0) begin failures++; $display("FAIL flush_cnt: got %0d want 0", flush_cnt_o); end
`endif
    xfer_cycle(1'b0, 8'h00, 96'h0, 1'b1, 1'b0);
    xfer_cycle(1'b0, 8'h00, 96'h0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_stall();
    xfer_cycle(1'b1, 8'h61, 96'hA6, 1'b0, 1'b0);
    xfer_cycle(1'b1, 8'h62, 96'hB6, 1'b0, 1'b0);
    do_reset();
    checks++;
    if (valid_o !== 1'b0 || ctrl_o !== 8'h00 || data_o !== 96'h0 || ready_o !== 1'b1 || stall_cnt_o !== 4'd0) begin
      failures++; $display("FAIL mid_rst: got v=%b c=%h d=%h r=%b s=%0d want 0/00/0/1/0", valid_o, ctrl_o, data_o, ready_o, stall_cnt_o);
    end
    xfer_cycle(1'b1, 8'h64, 96'hD0, 1'b0, 1'b0);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 96'hD0) begin
      failures++; $display("FAIL mid_rst_d: got v=%b d=%h want v=1 d=d0", valid_o, data_o);
    end
    xfer_cycle(1'b0, 8'h00, 96'h0, 1'b1, 1'b0);
    xfer_cycle(1'b0, 8'h00, 96'h0, 1'b1, 1'b0);
  endtask

  task automatic test_saturation();
    logic [NW-1:0] want;
`ifdef PIPE_STAGE_STATS_EN
    want = 4'd15;
`else
    want = 4'd0;
`endif
    do_reset();
    xfer_cycle(1'b1, 8'h71, 96'hE7, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) xfer_cycle(1'b0, 8'h00, 96'h0, 1'b0, 1'b0);
    checks++;
    if (stall_cnt_o !== want) begin failures++; $display("FAIL sat_20: got %0d want %0d", stall_cnt_o, want); end
    xfer_cycle(1'b0, 8'h00, 96'h0, 1'b0, 1'b0);
    xfer_cycle(1'b0, 8'h00, 96'h0, 1'b0, 1'b0);
    checks++;
    if (stall_cnt_o !== want) begin failures++; $display("FAIL sat_hold: got %0d want %0d", stall_cnt_o, want); end
    xfer_cycle(1'b0, 8'h00, 96'h0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      xfer_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(1, 255)),
                 {32'($urandom), 32'($urandom), 32'($urandom)},
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 3; i++) xfer_cycle(1'b0, 8'h00, 96'h0, 1'b1, 1'b0);
    checks++;
    if (exp_q.size() != 0 || valid_o !== 1'b0) begin
      failures++; $display("FAIL rand_drain: got q=%0d v=%b want q=0 v=0", exp_q.size(), valid_o);
    end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a ready/valid handshake, a two-entry skid buffer, and synchronous flush. It generalises the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block:
- Control and data payloads are packed vectors of configurable width.
- Backpressure stalls and hazard flushes are handled inside the block instead of by per-stage glue.
- Flushed or empty slots present an all-zero control field, so downstream stages see a bubble.

## Interface
Parameters:
- CTRL_W, 8: width of control payload; forced to zero on bubble/flush.
- DATA_W, 96: width of data payload; never cleared except by reset.
- CNT_W, 16: width of statistics counters.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  1  upstream entry valid.
- ready_o  out  1  block can accept an entry this cycle.
- ctrl_i  in  CTRL_W  upstream control fields (RegWrite, MemRead, ALUOp, ...).
- data_i  in  DATA_W  upstream data fields (operands, immediate, rs1/rs2/rd, funct).
- flush_i  in  1  discard all held entries and any entry offered this cycle.
- valid_o  out  1  downstream entry valid.
- ready_i  in  1  downstream accepts entry.
- ctrl_o  out  CTRL_W  head entry control; zero whenever valid_o=0.
- data_o  out  DATA_W  head entry data; holds last value when valid_o=0.
- stall_cnt_o  out  CNT_W  cycles with valid_o=1 and ready_i=0.
- flush_cnt_o  out  CNT_W  flush cycles that discarded at least one valid entry.

## Operation
Transfer definitions:
- in_xfer = valid_i & ready_o.
- out_xfer = valid_o & ready_i.

Storage:
- Head register (main): drives ctrl_o/data_o.
- Skid register: catches one entry accepted while the head is stalled.

States are derived from {main_v, skid_v}:
- EMPTY {0,0}: in_xfer -> FULL, main <= input.
- FULL {1,0}:
  - in_xfer & out_xfer -> FULL, main <= input.
  - in_xfer & ~out_xfer -> SKID, skid <= input.
  - ~in_xfer & out_xfer -> EMPTY.
  - Neither -> hold.
- SKID {1,1}: ready_o=0, so no input is accepted.
  - out_xfer -> FULL, main <= skid.
  - Otherwise hold.

Outputs and invariants:
- ready_o = ~skid_v (from register; no combinational path from ready_i).
- valid_o = main_v.
- ctrl_o = main_v ? main_ctrl : 0.
- Entry order is strictly preserved. No entry is duplicated or dropped except by flush.

Priority: rst_i > flush_i > handshake.
- flush_i=1: main_v, skid_v <= 0 and stored ctrl <= 0; stored data unchanged. An entry offered the same cycle is discarded even if ready_o=1. Next cycle the state is EMPTY.
- An out_xfer in the flush cycle still counts as delivered downstream (the downstream consumer sees valid_o=1 & ready_i=1 that cycle).

## Timing
- Reset values after a clock edge with rst_i=1:
  - valid_o=0, ctrl_o=0, data_o=0, ready_o=1.
  - stall_cnt_o=0, flush_cnt_o=0.
  - Skid contents are zeroed.
- Latency: 1 cycle from in_xfer to valid_o in EMPTY/FULL.
- Throughput: 1 entry/cycle with ready_i held high.
- ready_i falling: ready_o falls 1 cycle after the first entry is caught in skid. It rises the cycle after the skid drains.
- Reset mid-operation discards both entries without any output transfer. Reset during flush behaves as reset.
- Counters saturate at 2^CNT_W-1; they do not wrap.

## Configuration
- PIPE_STAGE_STATS_EN defined:
  - stall_cnt_o and flush_cnt_o are implemented as saturating counters.
  - Both are cleared only by rst_i.
- Not defined:
  - Counter logic is omitted.
  - Both ports remain present, tied to constant 0.
  - Handshake behaviour is identical in both builds.

## Test plan
- Streaming: after reset, send A,B,C on consecutive cycles with ready_i=1 -> valid_o high cycles 1-3, data_o=A,B,C, ready_o stays 1.
- Backpressure: FULL with A, ready_i=0, offer B -> B captured in skid, ready_o=0 next cycle. With ready_i=1 for two cycles -> outputs A then B, ready_o returns 1 after B moves to head. stall_cnt_o counts every stalled cycle (requires STATS_EN).
- Flush: SKID holding A,B, valid_i=1 with C, flush_i=1 -> next cycle valid_o=0, ctrl_o=0, ready_o=1, C never appears. flush_cnt_o=1 (requires STATS_EN).
- Bubble: EMPTY with CTRL_W=8 -> ctrl_o=8'h00 while data_o retains the last delivered value, e.g. 96'h..DEAD.
- Reset mid-stall: SKID state, assert rst_i one cycle -> all outputs at reset values, ready_o=1. A subsequent entry D appears alone one cycle later.
- Saturation (CNT_W=4, STATS_EN): hold valid_o=1 with ready_i=0 for 20 cycles -> stall_cnt_o=15 and stays at 15.
